// File: rtl/sid_table_sched.sv
// Shares one combined-waveform table among NUM_VOICES oscillators, one lookup sweep per ce_1m.
// Optional SID_TBL_SKIP_EN: skip lookups for voices whose inputs match their last captured snapshot.
module sid_table_sched #(
   parameter int NUM_VOICES = 3,
   parameter int LOOKUP_LAT = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce_1m,
   input  logic                      ovr_clr,
   input  logic [NUM_VOICES*12-1:0]  acc_ps,
   input  logic [NUM_VOICES*12-1:0]  acc_t,
   output logic [11:0]               tbl_acc_ps,
   output logic [11:0]               tbl_acc_t,
   input  logic [7:0]                tbl_st,
   input  logic [7:0]                tbl_pt,
   input  logic [7:0]                tbl_ps,
   input  logic [7:0]                tbl_pst,
   output logic [NUM_VOICES*8-1:0]   st_out,
   output logic [NUM_VOICES*8-1:0]   pt_out,
   output logic [NUM_VOICES*8-1:0]   ps_out,
   output logic [NUM_VOICES*8-1:0]   pst_out,
   output logic                      busy,
   output logic                      done,
   output logic                      overrun
);

   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CW = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [VW-1:0]  v;
   logic [CW-1:0]  cnt;
   logic [11:0]    snap_ps [NUM_VOICES];
   logic [11:0]    snap_t  [NUM_VOICES];
   logic           last_v;
   logic           abort;
   logic           skip;

   assign last_v = (v == VW'(NUM_VOICES - 1));
   assign abort  = ce_1m && (state == S_ISSUE || state == S_WAIT || state == S_CAPT);

`ifdef SID_TBL_SKIP_EN
   logic [11:0]           cap_ps [NUM_VOICES];
   logic [11:0]           cap_t  [NUM_VOICES];
   logic [NUM_VOICES-1:0] vld;

   assign skip = vld[v] && (cap_ps[v] == snap_ps[v]) && (cap_t[v] == snap_t[v]);
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ce_1m restarts from any state; in DONE this is a legal back-to-back sweep
   always_comb begin
      state_nxt = state;
      if (ce_1m) begin
         state_nxt = S_ISSUE;
      end else begin
         unique case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_ISSUE: state_nxt = skip ? (last_v ? S_DONE : S_ISSUE) : S_WAIT;
            S_WAIT:  state_nxt = (cnt == '0) ? S_CAPT : S_WAIT;
            S_CAPT:  state_nxt = last_v ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v          <= '0;
         cnt        <= '0;
         tbl_acc_ps <= '0;
         tbl_acc_t  <= '0;
         st_out     <= '0;
         pt_out     <= '0;
         ps_out     <= '0;
         pst_out    <= '0;
         overrun    <= 1'b0;
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            snap_ps[i] <= '0;
            snap_t[i]  <= '0;
`ifdef SID_TBL_SKIP_EN
            cap_ps[i]  <= '0;
            cap_t[i]   <= '0;
`endif
         end
`ifdef SID_TBL_SKIP_EN
         vld <= '0;
`endif
      end else begin
         if (abort)        overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;

         if (ce_1m) begin
            // a capture coinciding with ce_1m is dropped
            v <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
               snap_ps[i] <= acc_ps[12*i +: 12];
               snap_t[i]  <= acc_t[12*i +: 12];
            end
         end else begin
            unique case (state)
               S_ISSUE: begin
                  if (skip) begin
                     if (!last_v) v <= v + 1'b1;
                  end else begin
                     tbl_acc_ps <= snap_ps[v];
                     tbl_acc_t  <= snap_t[v];
                     cnt        <= CW'(LOOKUP_LAT - 1);
                  end
               end
               S_WAIT: begin
                  if (cnt != '0) cnt <= cnt - 1'b1;
               end
               S_CAPT: begin
                  for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                     if (v == VW'(i)) begin
                        st_out[8*i +: 8]  <= tbl_st;
                        pt_out[8*i +: 8]  <= tbl_pt;
                        ps_out[8*i +: 8]  <= tbl_ps;
                        pst_out[8*i +: 8] <= tbl_pst;
`ifdef SID_TBL_SKIP_EN
                        cap_ps[i] <= snap_ps[i];
                        cap_t[i]  <= snap_t[i];
                        vld[i]    <= 1'b1;
`endif
                     end
                  end
                  if (!last_v) v <= v + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sid_table_sched.sv
// Randomized and directed bench for sid_table_sched against a schedule-level reference model.
module tb_sid_table_sched;

   localparam int NV  = 3;
   localparam int LAT = 2;
`ifdef SID_TBL_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ce_1m = 1'b0;
   logic              ovr_clr = 1'b0;
   logic [NV*12-1:0]  acc_ps, acc_t;
   logic [11:0]       tbl_acc_ps, tbl_acc_t;
   logic [7:0]        tbl_st, tbl_pt, tbl_ps, tbl_pst;
   logic [NV*8-1:0]   st_out, pt_out, ps_out, pst_out;
   logic              busy, done, overrun;

   logic [11:0] ps_in [NV];
   logic [11:0] t_in  [NV];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NV; g++) begin : g_pack
      assign acc_ps[12*g +: 12] = ps_in[g];
      assign acc_t[12*g +: 12]  = t_in[g];
   end

   // table stand-in: two register stages from the registered address
   logic [11:0] p1_ps = '0, p1_t = '0, p2_ps = '0, p2_t = '0;
   always @(posedge clk) begin
      p1_ps <= tbl_acc_ps; p1_t <= tbl_acc_t;
      p2_ps <= p1_ps;      p2_t <= p1_t;
   end
   assign tbl_st  = p2_ps[7:0] ^ 8'hA5;
   assign tbl_pt  = p2_ps[7:0] + p2_t[7:0];
   assign tbl_ps  = p2_ps[11:4];
   assign tbl_pst = p2_t[7:0] ^ 8'h3C;

   sid_table_sched #(.NUM_VOICES(NV), .LOOKUP_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .ce_1m(ce_1m), .ovr_clr(ovr_clr),
      .acc_ps(acc_ps), .acc_t(acc_t),
      .tbl_acc_ps(tbl_acc_ps), .tbl_acc_t(tbl_acc_t),
      .tbl_st(tbl_st), .tbl_pt(tbl_pt), .tbl_ps(tbl_ps), .tbl_pst(tbl_pst),
      .st_out(st_out), .pt_out(pt_out), .ps_out(ps_out), .pst_out(pst_out),
      .busy(busy), .done(done), .overrun(overrun)
   );

   // reference model: expected results, last captured snapshots, and the planned sweep
   logic [7:0]  m_st [NV], m_pt [NV], m_ps [NV], m_pst [NV];
   logic [11:0] m_cap_ps [NV], m_cap_t [NV];
   bit          m_vld [NV];
   logic [11:0] s_ps [NV], s_t [NV];
   int          sc [NV];
   bit          sk [NV];
   int          sdone;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NV; i++) begin
         m_st[i] = '0; m_pt[i] = '0; m_ps[i] = '0; m_pst[i] = '0;
         m_cap_ps[i] = '0; m_cap_t[i] = '0; m_vld[i] = 1'b0;
      end
   endtask

   // snapshot current inputs and work out each voice's ISSUE cycle (cycle 1 follows the ce_1m edge)
   task automatic plan();
      int cyc = 1;
      for (int i = 0; i < NV; i++) begin
         s_ps[i] = ps_in[i];
         s_t[i]  = t_in[i];
         sk[i]   = SKIP && m_vld[i] && (m_cap_ps[i] == s_ps[i]) && (m_cap_t[i] == s_t[i]);
         sc[i]   = cyc;
         cyc    += sk[i] ? 1 : LAT + 2;
      end
      sdone = cyc;
   endtask

   // apply captures whose CAPT cycle ended before the edge closing cycle d
   task automatic commit(input int d);
      for (int i = 0; i < NV; i++) begin
         if (!sk[i] && (sc[i] + LAT + 1 < d)) begin
            m_st[i]  = s_ps[i][7:0] ^ 8'hA5;
            m_pt[i]  = s_ps[i][7:0] + s_t[i][7:0];
            m_ps[i]  = s_ps[i][11:4];
            m_pst[i] = s_t[i][7:0] ^ 8'h3C;
            m_cap_ps[i] = s_ps[i];
            m_cap_t[i]  = s_t[i];
            m_vld[i]    = 1'b1;
         end
      end
   endtask

   task automatic chk_outputs(input string tag);
      logic [NV*8-1:0] e_st, e_pt, e_ps, e_pst;
      for (int i = 0; i < NV; i++) begin
         e_st[8*i +: 8] = m_st[i]; e_pt[8*i +: 8] = m_pt[i];
         e_ps[8*i +: 8] = m_ps[i]; e_pst[8*i +: 8] = m_pst[i];
      end
      chk({tag, ".st"}, st_out, e_st);
      chk({tag, ".pt"}, pt_out, e_pt);
      chk({tag, ".ps"}, ps_out, e_ps);
      chk({tag, ".pst"}, pst_out, e_pst);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".tbl_acc_ps"}, tbl_acc_ps, 0);
      chk({tag, ".tbl_acc_t"}, tbl_acc_t, 0);
      chk({tag, ".outs"}, {st_out, pt_out, ps_out, pst_out}, 0);
      chk({tag, ".flags"}, {busy, done, overrun}, 0);
   endtask

   task automatic fresh_inputs();
      for (int i = 0; i < NV; i++) begin
         ps_in[i] = m_cap_ps[i] ^ 12'(1 + $urandom_range(0, 4094));
         t_in[i]  = 12'($urandom);
      end
   endtask

   task automatic ce_now();
      ce_1m = 1'b1;
      @(negedge clk);
      ce_1m = 1'b0;
   endtask

   // started=1: the ce_1m edge (and plan) already happened; chain=1: return in the DONE cycle
   task automatic run_sweep(input bit started, input int chg, input bit chain, output int dcyc);
      int busy_n = 0;
      dcyc = 0;
      if (!started) begin
         plan();
         ce_now();
      end
      for (int k = 1; k <= 60; k++) begin
         if (k == chg) ps_in[1] = ps_in[1] ^ 12'h5A5;
         for (int i = 0; i < NV; i++) begin
            if (!sk[i] && k == sc[i] + 1) begin
               chk("addr_ps", tbl_acc_ps, s_ps[i]);
               chk("addr_t", tbl_acc_t, s_t[i]);
            end
         end
         if (busy) busy_n++;
         if (done) begin
            dcyc = k;
            break;
         end
         @(negedge clk);
      end
      chk("done_cycle", dcyc, sdone);
      chk("busy_cycles", busy_n, sdone);
      commit(999);
      chk_outputs("sweep");
      if (!chain) begin
         @(negedge clk);
         chk("idle_flags", {busy, done}, 2'b00);
      end
   endtask

   initial begin
      int dc;
      int d;
      for (int i = 0; i < NV; i++) begin
         ps_in[i] = '0;
         t_in[i]  = '0;
      end
      model_reset();
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // directed sweep with a mid-sweep input change on voice 1
      ps_in[0] = 12'h011; ps_in[1] = 12'h022; ps_in[2] = 12'h033;
      t_in[0]  = 12'h104; t_in[1]  = 12'h2F0; t_in[2]  = 12'h0C3;
      run_sweep(0, 2, 0, dc);
      chk("len_default", dc, 13);
      chk("st_directed", st_out, 24'h9687B4);
      run_sweep(0, 0, 0, dc);
      chk("v1_new_snapshot", st_out[15:8], 8'h22);

`ifdef SID_TBL_SKIP_EN
      run_sweep(0, 0, 0, dc);
      chk("skip_all_len", dc, 4);
      ps_in[2] = ps_in[2] ^ 12'h001;
      run_sweep(0, 0, 0, dc);
      chk("skip_v2_len", dc, 7);
`endif

      // ce_1m landing exactly in the DONE cycle
      fresh_inputs();
      run_sweep(0, 0, 1, dc);
      fresh_inputs();
      run_sweep(0, 0, 0, dc);
      chk("done_ce_no_overrun", overrun, 1'b0);

      // overrun six cycles into a sweep, then a plain clear
      fresh_inputs();
      plan();
      ce_now();
      repeat (5) @(negedge clk);
      fresh_inputs();
      commit(6);
      plan();
      ce_now();
      chk("overrun_set", overrun, 1'b1);
      chk_outputs("abort6");
      run_sweep(1, 0, 0, dc);
      chk("overrun_sticky", overrun, 1'b1);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      chk("overrun_clr", overrun, 1'b0);

      // random abort points with ovr_clr coinciding with the overrun event
      for (int it = 0; it < 3; it++) begin
         fresh_inputs();
         plan();
         ce_now();
         d = $urandom_range(1, sdone - 1);
         repeat (d - 1) @(negedge clk);
         if (it != 0) fresh_inputs();
         commit(d);
         plan();
         ovr_clr = 1'b1;
         ce_now();
         ovr_clr = 1'b0;
         chk("overrun_set_wins", overrun, 1'b1);
         chk_outputs("abort_rand");
         run_sweep(1, 0, 0, dc);
         ovr_clr = 1'b1;
         @(negedge clk);
         ovr_clr = 1'b0;
         chk("overrun_clr_rand", overrun, 1'b0);
      end

      // reset during WAIT of voice 2
      fresh_inputs();
      plan();
      ce_now();
      repeat (sc[2]) @(negedge clk);
      reset = 1'b1;
      #1;
      chk_zero("reset_mid");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      run_sweep(0, 0, 0, dc);
      chk("len_after_reset", dc, 13);

      // randomized sweeps, some voices held, random mid-sweep disturbance
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NV; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               ps_in[i] = 12'($urandom);
               t_in[i]  = 12'($urandom);
            end
         end
         run_sweep(0, $urandom_range(0, 10), 0, dc);
         chk("rand_no_overrun", overrun, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sid_table_sched.md
Name: sid_table_sched

Overview:
- Time-multiplexes one shared combined-waveform table (acc_ps/acc_t in, _st/p_t/ps_/pst out) among NUM_VOICES oscillators.
- Sits between the voice instances and the single table instance in the SID top level, and replaces the ad-hoc phase counter there.
- Each ce_1m starts one sweep. A sweep looks up every voice in order and holds per-voice results stable until that voice is next captured.

Parameters:
NUM_VOICES, 3, number of voices served (1..6; 6 for dual-SID builds)
LOOKUP_LAT, 2, table read latency in clk cycles from address register to valid data (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ce_1m  in  1  1 MHz sweep-start strobe, one clk wide
ovr_clr  in  1  clears the overrun flag
acc_ps  in  NUM_VOICES*12  per-voice pulse/saw accumulator bits; voice v at [12v+11:12v]
acc_t  in  NUM_VOICES*12  per-voice triangle accumulator bits, same packing
tbl_acc_ps  out  12  address to shared table, registered
tbl_acc_t  out  12  address to shared table, registered
tbl_st  in  8  table _st result
tbl_pt  in  8  table p_t result
tbl_ps  in  8  table ps_ result
tbl_pst  in  8  table pst result
st_out  out  NUM_VOICES*8  per-voice _st result, voice v at [8v+7:8v]
pt_out  out  NUM_VOICES*8  per-voice p_t result
ps_out  out  NUM_VOICES*8  per-voice ps_ result
pst_out  out  NUM_VOICES*8  per-voice pst result
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse when a sweep completes
overrun  out  1  sticky; set when ce_1m arrives mid-sweep

Behaviour:
- Reset (asynchronous):
  - All outputs are 0.
  - State is IDLE, voice index v=0, wait counter 0.
  - Snapshot registers are 0 and all voice "valid" bits are cleared.
- States: IDLE, ISSUE, WAIT, CAPT, DONE.
- IDLE:
  - On ce_1m, snapshot all acc_ps/acc_t into internal registers, set v=0, go to ISSUE.
  - Lookups use only snapshot values; input changes during a sweep are ignored.
- ISSUE (1 cycle):
  - tbl_acc_ps/tbl_acc_t <= snapshot[v] at the ending edge.
  - Load the wait counter with LOOKUP_LAT-1, go to WAIT.
- WAIT (LOOKUP_LAT cycles):
  - Decrement the counter; go to CAPT when it is 0.
  - tbl_acc_* hold.
- CAPT (1 cycle):
  - At the ending edge, latch tbl_st/pt/ps/pst into voice v's output slices.
  - If v==NUM_VOICES-1, go to DONE; else v<=v+1 and go to ISSUE.
- DONE (1 cycle):
  - done=1 and busy=1; next state is IDLE.
  - A ce_1m in DONE is legal: the next state is ISSUE with a fresh snapshot, and done still pulses.
- Sweep length: NUM_VOICES*(LOOKUP_LAT+2)+1 cycles, measured from the ce_1m edge to the done pulse inclusive.
  - Defaults give 13 cycles. The integrator guarantees the ce_1m period exceeds this.
- Output update rules:
  - Only one voice's slices change per CAPT edge.
  - Other slices hold their values, including across reset release and aborts.
- Overrun: ce_1m while in ISSUE, WAIT or CAPT:
  - Set overrun.
  - Abort the current sweep with no capture on that edge, even if the state is CAPT.
  - Re-snapshot all inputs, set v=0, go to ISSUE.
  - Voices captured before the abort keep their new results; later voices keep their old ones.
- ovr_clr clears overrun. If ovr_clr coincides with an overrun event, set wins.
- tbl_acc_* are 0 after reset and otherwise hold their last issued address.

Optional Feature:
- Macro SID_TBL_SKIP_EN.
- Defined:
  - Each voice keeps the snapshot it last captured plus a valid bit; valid is set at that voice's CAPT.
  - In ISSUE, a voice whose valid bit is set and whose snapshot equals its last captured snapshot is skipped in 1 cycle: no address change, no WAIT/CAPT, outputs hold.
  - Valid bits clear on reset only. An aborted voice stays invalid if it was not captured.
- Not defined:
  - No comparison logic; every voice is always looked up.
  - Sweep length is always the fixed formula above.

Test Plan:
- Defaults, table model with LAT=2 returning {acc_ps[7:0]^8'hA5}; voices acc_ps=12'h011/12'h022/12'h033; pulse ce_1m -> busy for 13 cycles, done on cycle 13, st_out=24'h96_87_B4, tbl_acc_ps sequence 011,022,033.
- Change acc_ps of voice 1 two cycles after ce_1m -> results still reflect 12'h022 (snapshot); the next sweep picks up the new value.
- Second ce_1m 6 cycles after the first -> overrun=1, voice 0 updated, voices 1/2 old, restart from v=0; ovr_clr with no coincident event -> overrun=0; ovr_clr coincident with an event -> stays 1.
- ce_1m exactly in DONE cycle -> done pulses, overrun stays 0, new sweep starts next cycle with tbl_acc_ps=voice 0.
- Assert reset during WAIT for voice 2 -> all outputs 0 immediately, busy=0; the first ce_1m after release performs a full 13-cycle sweep.
- SID_TBL_SKIP_EN: two sweeps with identical inputs -> second sweep done after 3 skip cycles + DONE (4 cycles), outputs unchanged; change only voice 2 -> 1+1+4+1=7 cycles.
